// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared definitions for the hardwired CPU control unit:
//                opcode values, ALU function encodings (also used by the
//                ALU), sequencer state encoding, opcode classes and the
//                control strobe bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam int OPC_W = 5;
    localparam int ALU_W = 4;

    // Opcodes, ir[31:27]
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    // ALU function select
    localparam logic [ALU_W-1:0] ALU_NOP = 4'd0;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SHR = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SHL = 4'd4;
    localparam logic [ALU_W-1:0] ALU_ROR = 4'd5;
    localparam logic [ALU_W-1:0] ALU_ROL = 4'd6;
    localparam logic [ALU_W-1:0] ALU_AND = 4'd7;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'd8;
    localparam logic [ALU_W-1:0] ALU_MUL = 4'd9;
    localparam logic [ALU_W-1:0] ALU_DIV = 4'd10;
    localparam logic [ALU_W-1:0] ALU_NEG = 4'd11;
    localparam logic [ALU_W-1:0] ALU_NOT = 4'd12;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_HALTED = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_3REG    = 3'd1,   // Ra <= Rb op Rc
        CLS_MULDIV  = 3'd2,   // HI:LO <= Ra op Rb
        CLS_UNARY   = 3'd3,   // Ra <= op Rb
        CLS_NOP     = 3'd4,
        CLS_HALT    = 3'd5
    } op_class_t;

    typedef struct packed {
        logic             PCout;
        logic             PCin;
        logic             IncPC;
        logic             MARin;
        logic             Read;
        logic             MDRin;
        logic             MDRout;
        logic             IRin;
        logic             Yin;
        logic             Zin;
        logic             Zlowout;
        logic             ZHighout;
        logic             HIin;
        logic             LOin;
        logic             Gra;
        logic             Grb;
        logic             Grc;
        logic             Rin;
        logic             Rout;
        logic [ALU_W-1:0] alu_op;
    } strobes_t;

    function automatic op_class_t op_class(input logic [OPC_W-1:0] opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:  return CLS_3REG;
            OP_MUL, OP_DIV:                 return CLS_MULDIV;
            OP_NEG, OP_NOT:                 return CLS_UNARY;
            OP_NOP:                         return CLS_NOP;
            OP_HALT:                        return CLS_HALT;
            default:                        return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [ALU_W-1:0] op_alu(input logic [OPC_W-1:0] opcode);
        case (opcode)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_SHR:  return ALU_SHR;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            OP_NEG:  return ALU_NEG;
            OP_NOT:  return ALU_NOT;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode
//  Description : Purely combinational map from (sequencer state, opcode) to
//                the datapath strobe bundle.
//  Ports       : i_state   - current sequencer state
//                i_opcode  - opcode field of the IR
//                o_strobes - strobe bundle including alu_op
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t           i_state,
    input  logic [OPC_W-1:0] i_opcode,
    output strobes_t         o_strobes
);

    op_class_t w_cls;

    always_comb begin
        w_cls     = op_class(i_opcode);
        o_strobes = '0;
        o_strobes.alu_op = ALU_NOP;
        case (i_state)
            ST_T0: begin
                o_strobes.PCout = 1'b1;
                o_strobes.MARin = 1'b1;
                o_strobes.IncPC = 1'b1;
                o_strobes.Zin   = 1'b1;
            end
            ST_T1: begin
                o_strobes.Zlowout = 1'b1;
                o_strobes.PCin    = 1'b1;
                o_strobes.Read    = 1'b1;
                o_strobes.MDRin   = 1'b1;
            end
            ST_T2: begin
                o_strobes.MDRout = 1'b1;
                o_strobes.IRin   = 1'b1;
            end
            ST_T3: begin
                case (w_cls)
                    CLS_3REG: begin
                        o_strobes.Grb  = 1'b1;
                        o_strobes.Rout = 1'b1;
                        o_strobes.Yin  = 1'b1;
                    end
                    CLS_MULDIV: begin
                        o_strobes.Gra  = 1'b1;
                        o_strobes.Rout = 1'b1;
                        o_strobes.Yin  = 1'b1;
                    end
                    CLS_UNARY: begin
                        o_strobes.Grb    = 1'b1;
                        o_strobes.Rout   = 1'b1;
                        o_strobes.Zin    = 1'b1;
                        o_strobes.alu_op = op_alu(i_opcode);
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (w_cls)
                    CLS_3REG: begin
                        o_strobes.Grc    = 1'b1;
                        o_strobes.Rout   = 1'b1;
                        o_strobes.Zin    = 1'b1;
                        o_strobes.alu_op = op_alu(i_opcode);
                    end
                    CLS_MULDIV: begin
                        o_strobes.Grb    = 1'b1;
                        o_strobes.Rout   = 1'b1;
                        o_strobes.Zin    = 1'b1;
                        o_strobes.alu_op = op_alu(i_opcode);
                    end
                    CLS_UNARY: begin
                        o_strobes.Zlowout = 1'b1;
                        o_strobes.Gra     = 1'b1;
                        o_strobes.Rin     = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_cls)
                    CLS_3REG: begin
                        o_strobes.Zlowout = 1'b1;
                        o_strobes.Gra     = 1'b1;
                        o_strobes.Rin     = 1'b1;
                    end
                    CLS_MULDIV: begin
                        o_strobes.Zlowout = 1'b1;
                        o_strobes.LOin    = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (w_cls == CLS_MULDIV) begin
                    o_strobes.ZHighout = 1'b1;
                    o_strobes.HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Hardwired Moore control unit. Fetch T0-T2 with a memory
//                ready handshake and timeout, then execute T3-T6 according
//                to the opcode class. Holds the state register, the T1 wait
//                counter and the sticky fault flag.
//  Ports       : clock, clear (async active-low), run, mem_ready, ir[31:0]
//                datapath strobes, alu_op, running, halted, fault
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 5,
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                ZHighout,
    output logic                HIin,
    output logic                LOin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                running,
    output logic                halted,
    output logic                fault
);

    localparam int c_WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_fault;
    logic                w_fault_set;
    logic [OPC_W-1:0]    w_opcode;
    op_class_t           w_cls;
    state_t              w_end_state;
    logic                w_timeout;
    strobes_t            w_strobes;
    logic                w_unused_ir;

    assign w_opcode    = OPC_W'(ir[31 -: OPCODE_W]);
    assign w_unused_ir = ^ir[31-OPCODE_W:0];
    assign w_cls       = op_class(w_opcode);
    assign w_end_state = run ? ST_T0 : ST_IDLE;
    assign w_timeout   = (r_wait_cnt >= c_WAIT_W'(MEM_TIMEOUT - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Wait counter is held at zero outside T1, so it starts from zero on
    // every entry to T1; it stops at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_T1) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != '1) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_fault <= 1'b0;
        end else if (w_fault_set) begin
            r_fault <= 1'b1;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        w_fault_set  = 1'b0;
        case (r_state)
            ST_IDLE: w_state_next = run ? ST_T0 : ST_IDLE;
            ST_T0:   w_state_next = ST_T1;
            ST_T1: begin
                if (mem_ready) begin
                    w_state_next = ST_T2;
                end else if (w_timeout) begin
                    w_state_next = ST_HALTED;
                    w_fault_set  = 1'b1;
                end
            end
            // Branch on the opcode of the word being fetched.
            ST_T2: begin
                case (w_cls)
                    CLS_3REG, CLS_MULDIV, CLS_UNARY: w_state_next = ST_T3;
                    CLS_NOP:  w_state_next = w_end_state;
                    CLS_HALT: w_state_next = ST_HALTED;
                    default: begin
                        w_state_next = ST_HALTED;
                        w_fault_set  = 1'b1;
                    end
                endcase
            end
            ST_T3: w_state_next = ST_T4;
            ST_T4: w_state_next = (w_cls == CLS_UNARY) ? w_end_state : ST_T5;
            ST_T5: w_state_next = (w_cls == CLS_MULDIV) ? ST_T6 : w_end_state;
            ST_T6: w_state_next = w_end_state;
            ST_HALTED: w_state_next = ST_HALTED;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    ctrl_decode u_decode (
        .i_state   (r_state),
        .i_opcode  (w_opcode),
        .o_strobes (w_strobes)
    );

    always_comb begin
        running = (r_state != ST_IDLE) && (r_state != ST_HALTED);
        halted  = (r_state == ST_HALTED);
    end

    assign fault    = r_fault;
    assign PCout    = w_strobes.PCout;
    assign PCin     = w_strobes.PCin;
    assign IncPC    = w_strobes.IncPC;
    assign MARin    = w_strobes.MARin;
    assign Read     = w_strobes.Read;
    assign MDRin    = w_strobes.MDRin;
    assign MDRout   = w_strobes.MDRout;
    assign IRin     = w_strobes.IRin;
    assign Yin      = w_strobes.Yin;
    assign Zin      = w_strobes.Zin;
    assign Zlowout  = w_strobes.Zlowout;
    assign ZHighout = w_strobes.ZHighout;
    assign HIin     = w_strobes.HIin;
    assign LOin     = w_strobes.LOin;
    assign Gra      = w_strobes.Gra;
    assign Grb      = w_strobes.Grb;
    assign Grc      = w_strobes.Grc;
    assign Rin      = w_strobes.Rin;
    assign Rout     = w_strobes.Rout;
    assign alu_op   = ALU_OP_W'(w_strobes.alu_op);

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Directed self-checking bench for control_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    // Strobe bit positions in the observed vector (MSB first)
    localparam logic [18:0] B_PCOUT  = 19'h40000;
    localparam logic [18:0] B_PCIN   = 19'h20000;
    localparam logic [18:0] B_INCPC  = 19'h10000;
    localparam logic [18:0] B_MARIN  = 19'h08000;
    localparam logic [18:0] B_READ   = 19'h04000;
    localparam logic [18:0] B_MDRIN  = 19'h02000;
    localparam logic [18:0] B_MDROUT = 19'h01000;
    localparam logic [18:0] B_IRIN   = 19'h00800;
    localparam logic [18:0] B_YIN    = 19'h00400;
    localparam logic [18:0] B_ZIN    = 19'h00200;
    localparam logic [18:0] B_ZLO    = 19'h00100;
    localparam logic [18:0] B_ZHI    = 19'h00080;
    localparam logic [18:0] B_HIIN   = 19'h00040;
    localparam logic [18:0] B_LOIN   = 19'h00020;
    localparam logic [18:0] B_GRA    = 19'h00010;
    localparam logic [18:0] B_GRB    = 19'h00008;
    localparam logic [18:0] B_GRC    = 19'h00004;
    localparam logic [18:0] B_RIN    = 19'h00002;
    localparam logic [18:0] B_ROUT   = 19'h00001;

    localparam logic [18:0] E_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [18:0] E_T1 = B_ZLO | B_PCIN | B_READ | B_MDRIN;
    localparam logic [18:0] E_T2 = B_MDROUT | B_IRIN;

    localparam logic [3:0] A_NOP = 4'd0;
    localparam logic [3:0] A_ADD = 4'd1;
    localparam logic [3:0] A_ROL = 4'd6;
    localparam logic [3:0] A_MUL = 4'd9;
    localparam logic [3:0] A_NEG = 4'd11;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        run = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] ir = 32'h0;
    logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic Yin, Zin, Zlowout, ZHighout, HIin, LOin;
    logic Gra, Grb, Grc, Rin, Rout;
    logic [3:0] alu_op;
    logic running, halted, fault;
    logic [18:0] strb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    control_sequencer #(.OPCODE_W(5), .ALU_OP_W(4), .MEM_TIMEOUT(16)) dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .ZHighout(ZHighout), .HIin(HIin), .LOin(LOin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .running(running), .halted(halted), .fault(fault)
    );

    assign strb = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
                   Zlowout, ZHighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout};

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [18:0] es, input logic [3:0] ea,
                       input logic er, input logic eh, input logic ef);
        logic [25:0] obs;
        logic [25:0] exp;
        obs = {strb, alu_op, running, halted, fault};
        exp = {es, ea, er, eh, ef};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (strobes,alu_op,running,halted,fault)",
                   tag, obs, exp);
        end
    endtask

    // Fetch T0..T2; the new instruction word is presented after T0 is checked
    // so the previous instruction's last state still decodes its own opcode.
    task automatic fetch(input string tag, input logic [31:0] word);
        step(); chk({tag, "_t0"}, E_T0, A_NOP, 1'b1, 1'b0, 1'b0);
        ir = word;
        step(); chk({tag, "_t1"}, E_T1, A_NOP, 1'b1, 1'b0, 1'b0);
        step(); chk({tag, "_t2"}, E_T2, A_NOP, 1'b1, 1'b0, 1'b0);
    endtask

    // Exclusion rules, every cycle outside reset
    always @(negedge clock) begin
        if (clear) begin
            n_cmp++;
            assert (($onehot0({Gra, Grb, Grc}) && !(Rin && Rout) && !(Zlowout && ZHighout)) === 1'b1)
            else begin
                n_err++;
                $error("FAIL excl: observed Gra/Grb/Grc=%b Rin/Rout=%b Zlo/Zhi=%b expected exclusive",
                       {Gra, Grb, Grc}, {Rin, Rout}, {Zlowout, ZHighout});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        clear = 1'b0;
        step(); step();
        chk("reset", '0, A_NOP, 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        step(); chk("idle_run0", '0, A_NOP, 1'b0, 1'b0, 1'b0);

        // rol R1,R2,R3
        run = 1'b1;
        fetch("rol", 32'h40918000);
        step(); chk("rol_t3", B_GRB | B_ROUT | B_YIN, A_NOP, 1'b1, 1'b0, 1'b0);
        step(); chk("rol_t4", B_GRC | B_ROUT | B_ZIN, A_ROL, 1'b1, 1'b0, 1'b0);
        step(); chk("rol_t5", B_ZLO | B_GRA | B_RIN, A_NOP, 1'b1, 1'b0, 1'b0);

        // mul R2,R3 (fetch also proves rol returned straight to T0)
        fetch("mul", 32'h79180000);
        step(); chk("mul_t3", B_GRA | B_ROUT | B_YIN, A_NOP, 1'b1, 1'b0, 1'b0);
        step(); chk("mul_t4", B_GRB | B_ROUT | B_ZIN, A_MUL, 1'b1, 1'b0, 1'b0);
        step(); chk("mul_t5", B_ZLO | B_LOIN, A_NOP, 1'b1, 1'b0, 1'b0);
        step(); chk("mul_t6", B_ZHI | B_HIIN, A_NOP, 1'b1, 1'b0, 1'b0);

        // neg
        fetch("neg", 32'h88000000);
        step(); chk("neg_t3", B_GRB | B_ROUT | B_ZIN, A_NEG, 1'b1, 1'b0, 1'b0);
        step(); chk("neg_t4", B_ZLO | B_GRA | B_RIN, A_NOP, 1'b1, 1'b0, 1'b0);

        // nop ends after T2
        fetch("nop", 32'hD0000000);

        // Memory wait: mem_ready low for 3 T1 cycles -> 4 T1 cycles
        step(); chk("wait_t0", E_T0, A_NOP, 1'b1, 1'b0, 1'b0);
        ir = 32'h18000000;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); chk("wait_t1", E_T1, A_NOP, 1'b1, 1'b0, 1'b0);
            if (i == 3) mem_ready = 1'b1;
        end
        step(); chk("wait_t2", E_T2, A_NOP, 1'b1, 1'b0, 1'b0);

        // run dropped in T3 of add: completes, then IDLE
        step(); chk("add_t3", B_GRB | B_ROUT | B_YIN, A_NOP, 1'b1, 1'b0, 1'b0);
        run = 1'b0;
        step(); chk("add_t4", B_GRC | B_ROUT | B_ZIN, A_ADD, 1'b1, 1'b0, 1'b0);
        step(); chk("add_t5", B_ZLO | B_GRA | B_RIN, A_NOP, 1'b1, 1'b0, 1'b0);
        step(); chk("add_idle", '0, A_NOP, 1'b0, 1'b0, 1'b0);

        // Reset pulse in T4 drops strobes immediately
        run = 1'b1;
        fetch("add2", 32'h18000000);
        step(); chk("add2_t3", B_GRB | B_ROUT | B_YIN, A_NOP, 1'b1, 1'b0, 1'b0);
        step(); chk("add2_t4", B_GRC | B_ROUT | B_ZIN, A_ADD, 1'b1, 1'b0, 1'b0);
        #1 clear = 1'b0;
        #1 chk("clear_mid", '0, A_NOP, 1'b0, 1'b0, 1'b0);
        run = 1'b0;
        step(); clear = 1'b1;
        step(); chk("clear_idle", '0, A_NOP, 1'b0, 1'b0, 1'b0);

        // Memory timeout: 16 T1 cycles, then HALTED with fault
        run = 1'b1;
        mem_ready = 1'b0;
        step(); chk("to_t0", E_T0, A_NOP, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(); chk("to_t1", E_T1, A_NOP, 1'b1, 1'b0, 1'b0);
        end
        step(); chk("to_halt", '0, A_NOP, 1'b0, 1'b1, 1'b1);
        run = 1'b0;
        step(); chk("to_sticky", '0, A_NOP, 1'b0, 1'b1, 1'b1);
        clear = 1'b0;
        step(); clear = 1'b1;
        mem_ready = 1'b1;
        step(); chk("to_cleared", '0, A_NOP, 1'b0, 1'b0, 1'b0);

        // halt: HALTED without fault, run has no effect
        run = 1'b1;
        fetch("halt", 32'hD8000000);
        step(); chk("halt_st", '0, A_NOP, 1'b0, 1'b1, 1'b0);
        run = 1'b0;
        step(); chk("halt_run0", '0, A_NOP, 1'b0, 1'b1, 1'b0);
        run = 1'b1;
        step(); chk("halt_run1", '0, A_NOP, 1'b0, 1'b1, 1'b0);
        clear = 1'b0;
        step(); clear = 1'b1;

        // Illegal opcode 11111
        fetch("ill", 32'hF8000000);
        step(); chk("ill_halt", '0, A_NOP, 1'b0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
